// File: rtl/seg_scan4_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg_scan4_pkg
// Purpose  : Shared 7-segment definitions for the display blocks. Patterns
//            are active-high with bit order {dp,g,f,e,d,c,b,a} (a = bit 0).
// Contents : bcd_t / seg_t types, SEG_0..SEG_9, SEG_DASH, SEG_BLANK,
//            bcd_to_seg() helper (values 10..15 map to a dash).
// Revision : 1.0 - initial release
// ============================================================================
package seg_scan4_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] seg_t;

    localparam int NUM_DIGITS = 4;

    localparam seg_t SEG_0     = 8'h3F;
    localparam seg_t SEG_1     = 8'h06;
    localparam seg_t SEG_2     = 8'h5B;
    localparam seg_t SEG_3     = 8'h4F;
    localparam seg_t SEG_4     = 8'h66;
    localparam seg_t SEG_5     = 8'h6D;
    localparam seg_t SEG_6     = 8'h7D;
    localparam seg_t SEG_7     = 8'h07;
    localparam seg_t SEG_8     = 8'h7F;
    localparam seg_t SEG_9     = 8'h6F;
    localparam seg_t SEG_DASH  = 8'h40;
    localparam seg_t SEG_BLANK = 8'h00;

    // Non-decimal codes render as a dash so a corrupted counter digit is
    // visible rather than silently shown as some numeral.
    function automatic seg_t bcd_to_seg(input bcd_t d);
        seg_t p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_DASH;
        endcase
        return p;
    endfunction

endpackage : seg_scan4_pkg
`default_nettype wire

// File: rtl/seg_scan4_if.sv
`default_nettype none
// ============================================================================
// Interface : seg_scan4_if
// Purpose   : Bundles the digit inputs and display outputs of seg_scan4.
// Signals   : bcd0..bcd3 (4b each, units..thousands), update (1b),
//             seg (8b {dp,g..a}), dig_sel (4b, bit i = digit i), frame (1b)
// Modports  : master - digit source / display observer
//             slave  - the scan driver (seg_scan4)
// Revision  : 1.0 - initial release
// ============================================================================
interface seg_scan4_if;
    import seg_scan4_pkg::*;

    bcd_t       bcd0;
    bcd_t       bcd1;
    bcd_t       bcd2;
    bcd_t       bcd3;
    logic       update;
    seg_t       seg;
    logic [3:0] dig_sel;
    logic       frame;

    modport master (
        output bcd0,
        output bcd1,
        output bcd2,
        output bcd3,
        output update,
        input  seg,
        input  dig_sel,
        input  frame
    );

    modport slave (
        input  bcd0,
        input  bcd1,
        input  bcd2,
        input  bcd3,
        input  update,
        output seg,
        output dig_sel,
        output frame
    );

endinterface : seg_scan4_if
`default_nettype wire

// File: rtl/seg_scan4_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational BCD to 7-segment decoder with blank override.
//            Output is always active-high; polarity is applied by the user.
// Ports    : bcd     in  4  digit value (10..15 decode as a dash)
//            blank   in  1  1 = force all segments off
//            pattern out 8  {dp,g,f,e,d,c,b,a}, dp always 0
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg_scan4_pkg::*;
(
    input  bcd_t bcd,
    input  logic blank,
    output seg_t pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank) begin
            pattern = bcd_to_seg(bcd);
        end
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg_scan4.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan4
// Purpose  : 4-digit multiplexed 7-segment scan driver for the frequency
//            meter. Snapshots the counter digits at frame boundaries,
//            blanks leading zeros and rotates the digit selects with a
//            dead time after every switch to avoid ghosting.
// Ports    : clk      in  1  system clock
//            rst_n    in  1  asynchronous active-low reset
//            bus      slave modport of seg_scan4_if:
//              bcd0..3 in  4 each  units..thousands digits
//              update  in  1       1 = refresh snapshot at next frame
//              seg     out 8       {dp,g..a}, polarity per SEG_ACT_LOW
//              dig_sel out 4       digit enables, polarity per DIG_ACT_LOW
//              frame   out 1       1-clk pulse at each frame boundary
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan4
    import seg_scan4_pkg::*;
#(
    parameter int CLK_FRE     = 12_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int DEAD_CYC    = 4,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    seg_scan4_if.slave   bus
);

    localparam int SCAN_DIV = CLK_FRE / SCAN_HZ;
    localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEAD_W   = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    localparam logic [CNT_W-1:0]  C_CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [DEAD_W-1:0] C_DEAD_LOAD = DEAD_W'(DEAD_CYC);
    localparam logic [DEAD_W-1:0] C_DEAD_ONE  = DEAD_W'(1);
    localparam logic [1:0]        C_IDX_LAST  = 2'd3;
    localparam seg_t              C_SEG_OFF   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0]        C_DIG_OFF   = (DIG_ACT_LOW != 0) ? 4'hF : 4'h0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_idx;
    logic [DEAD_W-1:0] r_dead;
    bcd_t [3:0]        r_shadow;
    seg_t              r_seg;
    logic [3:0]        r_dig_sel;
    logic              r_frame;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic              w_tick;
    logic              w_frame_tick;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        w_idx_nxt;
    logic [DEAD_W-1:0] w_dead_nxt;
    logic [3:0]        w_dig_hi;
    logic [3:0]        w_dig_nxt;

    assign w_tick       = (r_cnt == C_CNT_MAX);
    assign w_frame_tick = w_tick && (r_idx == C_IDX_LAST);

    always_comb begin
        w_cnt_nxt  = r_cnt + C_CNT_ONE;
        w_idx_nxt  = r_idx;
        w_dead_nxt = r_dead;
        if (w_tick) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = r_idx + 2'd1;
            w_dead_nxt = C_DEAD_LOAD;
        end else if (r_dead != '0) begin
            w_dead_nxt = r_dead - C_DEAD_ONE;
        end
    end

    // The select register is computed from next-state idx/dead so the enable
    // lines up exactly with the dead counter reaching zero, and stays off
    // through reset until the counter says otherwise.
    always_comb begin
        w_dig_hi  = 4'b0001 << w_idx_nxt;
        w_dig_nxt = C_DIG_OFF;
        if (w_dead_nxt == '0) begin
            w_dig_nxt = (DIG_ACT_LOW != 0) ? ~w_dig_hi : w_dig_hi;
        end
    end

    // ------------------------------------------------------------------------
    // Leading-zero blanking, evaluated on the snapshot so it is frame-stable.
    // Any nonzero code, including invalid ones, breaks the blanking chain.
    // ------------------------------------------------------------------------
    logic       w_lz_en;
    logic [3:0] w_blank;

    assign w_lz_en = (BLANK_LZ != 0);

    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = w_lz_en && (r_shadow[3] == 4'd0);
        w_blank[2] = w_blank[3] && (r_shadow[2] == 4'd0);
        w_blank[1] = w_blank[2] && (r_shadow[1] == 4'd0);
    end

    // ------------------------------------------------------------------------
    // Segment decode of the currently selected digit
    // ------------------------------------------------------------------------
    bcd_t w_cur_bcd;
    logic w_cur_blank;
    seg_t w_pattern;
    seg_t w_seg_nxt;

    assign w_cur_bcd   = r_shadow[r_idx];
    assign w_cur_blank = w_blank[r_idx];

    seg7_decode u_decode (
        .bcd     (w_cur_bcd),
        .blank   (w_cur_blank),
        .pattern (w_pattern)
    );

    assign w_seg_nxt = (SEG_ACT_LOW != 0) ? ~w_pattern : w_pattern;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_dead    <= '0;
            r_shadow  <= '0;
            r_seg     <= C_SEG_OFF;
            r_dig_sel <= C_DIG_OFF;
            r_frame   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_dead    <= w_dead_nxt;
            r_seg     <= w_seg_nxt;
            r_dig_sel <= w_dig_nxt;
            r_frame   <= w_frame_tick;
            // Inputs are only looked at on the frame-boundary tick, so the
            // counter may update its digits freely at any other time.
            if (w_frame_tick && bus.update) begin
                r_shadow <= {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
            end
        end
    end

    assign bus.seg     = r_seg;
    assign bus.dig_sel = r_dig_sel;
    assign bus.frame   = r_frame;

endmodule : seg_scan4
`default_nettype wire

// File: tb/tb_seg_scan4.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan4
// Purpose  : Self-checking bench for seg_scan4 (SCAN_DIV=10, DEAD_CYC=2,
//            active-low outputs, leading-zero blanking on).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan4;
    import seg_scan4_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Expected frames: {d3,d2,d1,d0} active-low segment bytes, d0 in [7:0].
    logic [31:0] sb_q [$];

    // One captured frame: k = 0 is the frame-pulse cycle.
    logic [7:0] obs_seg   [40];
    logic [3:0] obs_dig   [40];
    logic       obs_frame [40];
    int         gap;
    bit         got;

    seg_scan4_if bus ();

    seg_scan4 #(
        .CLK_FRE     (1000),
        .SCAN_HZ     (100),
        .DEAD_CYC    (2),
        .SEG_ACT_LOW (1),
        .DIG_ACT_LOW (1),
        .BLANK_LZ    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic set_bcd(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        bus.bcd3 = d3;
        bus.bcd2 = d2;
        bus.bcd1 = d1;
        bus.bcd0 = d0;
    endtask

    // Arguments are active-high patterns; the display is active-low.
    task automatic push_exp(input seg_t p3, input seg_t p2, input seg_t p1, input seg_t p0);
        sb_q.push_back({~p3, ~p2, ~p1, ~p0});
    endtask

    task automatic pop_exp(output logic [31:0] e);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else                  e = 'x;
    endtask

    // Waits (bounded) for the next frame pulse and records 40 cycles.
    task automatic capture_frame();
        got = 0;
        gap = 0;
        while (!got && gap < 100) begin
            @(negedge clk);
            gap++;
            if (bus.frame === 1'b1) got = 1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout waited=%0d cycles, required a frame pulse", gap);
        end
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            obs_seg[k]   = bus.seg;
            obs_dig[k]   = bus.dig_sel;
            obs_frame[k] = bus.frame;
        end
    endtask

    task automatic test_reset();
        bus.update = 1'b0;
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.seg !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h want=ff", bus.seg); end
        checks++;
        if (bus.dig_sel !== 4'hF) begin failures++; $display("FAIL reset_dig got=%h want=f", bus.dig_sel); end
        checks++;
        if (bus.frame !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b want=0", bus.frame); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.seg !== 8'hFF || bus.dig_sel !== 4'hF) begin
            failures++;
            $display("FAIL release_idle got seg=%h dig=%h want seg=ff dig=f", bus.seg, bus.dig_sel);
        end
        // 15 clocks in: slot 1 has passed its dead time and is lit.
        repeat (15) @(negedge clk);
        checks++;
        if (bus.dig_sel !== 4'b1101) begin failures++; $display("FAIL scan_slot1 got=%b want=1101", bus.dig_sel); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.seg !== 8'hFF || bus.dig_sel !== 4'hF || bus.frame !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got seg=%h dig=%h frame=%b want seg=ff dig=f frame=0",
                     bus.seg, bus.dig_sel, bus.frame);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        logic [31:0] e;
        int          errs;
        logic [3:0]  want;
        bus.update = 1'b1;
        set_bcd(4'd1, 4'd2, 4'd3, 4'd4);
        push_exp(SEG_1, SEG_2, SEG_3, SEG_4);
        capture_frame();
        pop_exp(e);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_seg[10*i+5] !== e[8*i +: 8]) begin
                failures++;
                $display("FAIL load_seg_d%0d got=%h want=%h", i, obs_seg[10*i+5], e[8*i +: 8]);
            end
        end
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            want = (k % 10 < 2) ? 4'hF : 4'(~(4'b0001 << (k / 10)));
            if (obs_dig[k] !== want || obs_frame[k] !== (k == 0)) errs++;
        end
        checks++;
        if (errs != 0) begin failures++; $display("FAIL load_scan_sequence bad_cycles=%0d want=0", errs); end
    endtask

    task automatic test_blank();
        logic [31:0] e;
        set_bcd(4'd0, 4'd0, 4'd0, 4'd7);
        push_exp(SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_7);
        capture_frame();
        pop_exp(e);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_seg[10*i+5] !== e[8*i +: 8]) begin
                failures++;
                $display("FAIL blank7_seg_d%0d got=%h want=%h", i, obs_seg[10*i+5], e[8*i +: 8]);
            end
        end
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
        push_exp(SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0);
        capture_frame();
        pop_exp(e);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_seg[10*i+5] !== e[8*i +: 8]) begin
                failures++;
                $display("FAIL blank0_seg_d%0d got=%h want=%h", i, obs_seg[10*i+5], e[8*i +: 8]);
            end
        end
        // Blanked digits still get their enable slot.
        checks++;
        if (obs_dig[35] !== 4'b0111) begin failures++; $display("FAIL blank_slot3_dig got=%b want=0111", obs_dig[35]); end
    endtask

    task automatic test_invalid();
        logic [31:0] e;
        set_bcd(4'd0, 4'hC, 4'd0, 4'd5);
        push_exp(SEG_BLANK, SEG_DASH, SEG_0, SEG_5);
        capture_frame();
        pop_exp(e);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_seg[10*i+5] !== e[8*i +: 8]) begin
                failures++;
                $display("FAIL invalid_seg_d%0d got=%h want=%h", i, obs_seg[10*i+5], e[8*i +: 8]);
            end
        end
    endtask

    task automatic test_tearing();
        logic [31:0] e;
        set_bcd(4'd2, 4'd0, 4'd2, 4'd5);
        push_exp(SEG_2, SEG_0, SEG_2, SEG_5);
        capture_frame();
        pop_exp(e);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_seg[10*i+5] !== e[8*i +: 8]) begin
                failures++;
                $display("FAIL tear_load_seg_d%0d got=%h want=%h", i, obs_seg[10*i+5], e[8*i +: 8]);
            end
        end
        // Freeze: we sit in the boundary tick cycle, so this frame already holds.
        bus.update = 1'b0;
        for (int f = 0; f < 3; f++) begin
            push_exp(SEG_2, SEG_0, SEG_2, SEG_5);
            fork
                capture_frame();
                begin
                    repeat (40) begin
                        set_bcd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                        @(negedge clk);
                    end
                end
            join
            pop_exp(e);
            checks++;
            if (gap !== 1) begin failures++; $display("FAIL tear_frame_period frame=%0d gap=%0d want=1", f, gap); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_seg[10*i+5] !== e[8*i +: 8]) begin
                    failures++;
                    $display("FAIL tear_hold_f%0d_d%0d got=%h want=%h", f, i, obs_seg[10*i+5], e[8*i +: 8]);
                end
            end
        end
        bus.update = 1'b1;
        set_bcd(4'd9, 4'd8, 4'd6, 4'd5);
        push_exp(SEG_9, SEG_8, SEG_6, SEG_5);
        capture_frame();
        pop_exp(e);
        checks++;
        if (gap !== 1) begin failures++; $display("FAIL tear_resume_period gap=%0d want=1", gap); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_seg[10*i+5] !== e[8*i +: 8]) begin
                failures++;
                $display("FAIL tear_resume_seg_d%0d got=%h want=%h", i, obs_seg[10*i+5], e[8*i +: 8]);
            end
        end
    endtask

    task automatic test_dead_time();
        logic [31:0] e;
        int          errs;
        int          off_run;
        logic [3:0]  want;
        set_bcd(4'd9, 4'd0, 4'd4, 4'd1);
        push_exp(SEG_9, SEG_0, SEG_4, SEG_1);
        capture_frame();
        pop_exp(e);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_seg[10*i+5] !== e[8*i +: 8]) begin
                failures++;
                $display("FAIL dead_seg_d%0d got=%h want=%h", i, obs_seg[10*i+5], e[8*i +: 8]);
            end
        end
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            want = (k % 10 < 2) ? 4'hF : 4'(~(4'b0001 << (k / 10)));
            if (obs_dig[k] !== want) errs++;
        end
        checks++;
        if (errs != 0) begin failures++; $display("FAIL dead_dig_sequence bad_cycles=%0d want=0", errs); end
        // Each slot must open with exactly two all-off cycles.
        errs = 0;
        off_run = 0;
        for (int k = 0; k < 40; k++) begin
            if (obs_dig[k] === 4'hF) off_run++;
            else begin
                if (k > 0 && obs_dig[k-1] === 4'hF && off_run != 2) errs++;
                off_run = 0;
            end
        end
        checks++;
        if (errs != 0) begin failures++; $display("FAIL dead_time_length bad_slots=%0d want=0", errs); end
        errs = 0;
        for (int k = 1; k < 40; k++) begin
            if (obs_dig[k] !== 4'hF && obs_dig[k] === obs_dig[k-1] && obs_seg[k] !== obs_seg[k-1]) errs++;
        end
        checks++;
        if (errs != 0) begin failures++; $display("FAIL seg_change_while_lit events=%0d want=0", errs); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_blank();
        test_invalid();
        test_tearing();
        test_dead_time();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seg_scan4
`default_nettype wire
